microcode_issue_queue: RTL

- Parametrised FIFO of decoded micro-op words sitting between the decode stage and the execute units; successor to the single decode/execute pipeline register.
- Decouples decode from execute with DEPTH entries.
- Holds the head entry while its source registers collide with an in-flight load destination, giving load-use interlock.
- Supports pipeline flush on branch/jump redirect.

---
 rtl/microcode_issue_queue.sv | 99 +++++++++
 1 files changed

// File: rtl/microcode_issue_queue.sv
// Issue queue of decoded micro-ops between decode and execute, with load-use interlock and flush.
// Optional same-cycle empty-queue bypass is compiled in with MICROCODE_QUEUE_BYPASS_EN.
module microcode_issue_queue #(
    parameter int DEPTH = 4,
    parameter int UOP_W = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UOP_W-1:0] in_uop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [UOP_W-1:0] out_uop,
    input  logic             ld_pend_valid,
    input  logic [4:0]       ld_pend_rd,
    output logic [CNT_W-1:0] count,
    output logic             stall_hazard
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [UOP_W-1:0] w_entries [DEPTH];
    logic [UOP_W-1:0] w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_head_hazard;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    // x0 is hardwired zero, so a pending load targeting it never blocks issue.
    function automatic logic f_hazard(input logic [UOP_W-1:0] uop,
                                      input logic pend_valid,
                                      input logic [4:0] pend_rd);
        return pend_valid && (pend_rd != 5'd0) &&
               ((pend_rd == uop[UOP_W-1 -: 5]) || (pend_rd == uop[UOP_W-6 -: 5]));
    endfunction

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_head        = w_entries[r_rd_ptr];
    assign w_head_hazard = f_hazard(w_head, ld_pend_valid, ld_pend_rd);

    // Ready never depends on out_ready, so a full queue cannot accept even when draining.
    assign in_ready = !w_full && !flush && !reset;

`ifdef MICROCODE_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && in_valid && in_ready && out_ready &&
                      !f_hazard(in_uop, ld_pend_valid, ld_pend_rd);
    assign out_uop  = w_bypass ? in_uop : w_head;
`else
    assign w_bypass = 1'b0;
    assign out_uop  = w_head;
`endif

    assign out_valid    = w_bypass || (!w_empty && !w_head_hazard && !flush);
    assign stall_hazard = !w_empty && w_head_hazard;
    assign count        = r_count;

    assign w_push = in_valid && in_ready && !w_bypass;
    assign w_pop  = out_valid && out_ready && !w_bypass;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [UOP_W-1:0] r_entry;
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_entry <= in_uop;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end
endmodule
